pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arbiter_if.sv | 24 ++
 rtl/pci_arbiter.sv | 120 ++++++++++++
 tb/tb_pci_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pci_arbiter_if.sv
// Bus-side signals shared by the PCI arbiter and the devices it serves.
// The arbiter uses the master modport. The devices, or a testbench, use the slave modport.
interface pci_arbiter_if #(
    parameter int NDEV = 4
);
    localparam int AW = $clog2(NDEV);

    logic [NDEV-1:0] req_n;
    logic            frame_n;
    logic            irdy_n;
    logic [NDEV-1:0] gnt_n;
    logic [AW-1:0]   owner;
    logic            bus_busy;

    modport master (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy
    );

    modport slave (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy
    );
endinterface

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with a grant timeout and a bus-turnaround guarantee.
//   state | meaning
//   IDLE  | no grant; pick next requester once FRAME#/IRDY# are both high
//   GRANT | one gnt_n low; wait for FRAME#, a dropped request, or timeout
//   BUSY  | transaction in progress; no grants until the bus goes idle
module pci_arbiter #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          reset,
    pci_arbiter_if.master bus
);
    localparam int AW = $clog2(NDEV);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t          state, state_next;
    logic [NDEV-1:0] gnt, gnt_next;
    logic [AW-1:0]   owner, owner_next;
    logic [AW-1:0]   last_owner, last_owner_next;
    logic [CW-1:0]   count, count_next;
    logic            busy, busy_next;

    logic [AW-1:0]   winner;
    logic [AW-1:0]   idx;
    logic            found;
    logic            bus_idle;

    assign bus_idle = bus.frame_n & bus.irdy_n;

    // Search starts just past the previous owner, so that owner has the lowest priority.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NDEV; k++) begin
            idx = AW'((int'(last_owner) + k) % NDEV);
            if (!found && !bus.req_n[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        owner_next      = owner;
        last_owner_next = last_owner;
        count_next      = count;
        case (state)
            IDLE: begin
                gnt_next   = '1;
                count_next = '0;
                if (found && bus_idle) begin
                    state_next = GRANT;
                    owner_next = winner;
                    gnt_next   = ~(NDEV'(1) << winner);
                end
            end
            GRANT: begin
                if (!bus.frame_n) begin
                    state_next      = BUSY;
                    gnt_next        = '1;
                    last_owner_next = owner;
                    count_next      = '0;
                end else if (bus.req_n[owner]) begin
                    state_next = IDLE;
                    gnt_next   = '1;
                    count_next = '0;
                end else if (count == CW'(TIMEOUT - 1)) begin
                    // The timed-out device drops to the lowest priority.
                    state_next      = IDLE;
                    gnt_next        = '1;
                    last_owner_next = owner;
                    count_next      = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            BUSY: begin
                gnt_next   = '1;
                count_next = '0;
                if (bus_idle) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '1;
                count_next = '0;
            end
        endcase
        busy_next = (state_next == BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '1;
            owner      <= '0;
            last_owner <= AW'(NDEV - 1);
            count      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            count      <= count_next;
            busy       <= busy_next;
        end
    end

    assign bus.gnt_n    = gnt;
    assign bus.owner    = owner;
    assign bus.bus_busy = busy;
endmodule

// File: tb/tb_pci_arbiter.sv
// Directed and randomized bench for pci_arbiter.
// It is checked against a grant-level reference model.
module tb_pci_arbiter;
    logic clk = 1'b0;
    logic reset;

    pci_arbiter_if #(.NDEV(4)) bus ();

    pci_arbiter #(.NDEV(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: whether a grant or transfer is pending, who holds it, and how long it has been held.
    bit m_granted;
    bit m_transfer;
    int m_owner;
    int m_last;
    int m_age;

    function automatic logic [3:0] m_gnt();
        logic [3:0] one;
        one = 4'b0001;
        return m_granted ? ~(one << m_owner) : 4'hF;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_granted  = 0;
            m_transfer = 0;
            m_owner    = 0;
            m_last     = 3;
            m_age      = 0;
        end else if (m_transfer) begin
            if (bus.frame_n && bus.irdy_n) m_transfer = 0;
        end else if (m_granted) begin
            if (!bus.frame_n) begin
                m_granted  = 0;
                m_transfer = 1;
                m_last     = m_owner;
            end else if (bus.req_n[m_owner]) begin
                m_granted = 0;
            end else if (m_age == 15) begin
                m_granted = 0;
                m_last    = m_owner;
            end else begin
                m_age++;
            end
        end else if (bus.req_n != 4'hF && bus.frame_n && bus.irdy_n) begin
            for (int k = 1; k <= 4; k++) begin
                if (!bus.req_n[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    break;
                end
            end
            m_granted = 1;
            m_age     = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("gnt_n", 32'(bus.gnt_n), 32'(m_gnt()));
        check("owner", 32'(bus.owner), 32'(m_owner));
        check("bus_busy", 32'(bus.bus_busy), 32'(m_transfer));
        check("one_grant", 32'($countones(~bus.gnt_n) <= 1), 32'd1);
    endtask

    int cnt;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset       = 1'b1;
        bus.req_n   = 4'hF;
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b1;
        step();
        step();
        check("reset_gnt", 32'(bus.gnt_n), 32'hF);
        check("reset_owner", 32'(bus.owner), 32'd0);

        // The first grant after reset goes to device 0.
        reset     = 1'b0;
        bus.req_n = 4'b0000;
        step();
        check("first_grant", 32'(bus.gnt_n), 32'b1110);

        // Device 0 runs a 3-cycle transfer. Device 1 is served next.
        bus.frame_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_during", 32'(bus.bus_busy), 32'd1);
        end
        bus.frame_n = 1'b1;
        step();
        check("busy_after", 32'(bus.bus_busy), 32'd0);
        step();
        check("next_dev1", 32'(bus.gnt_n), 32'b1101);

        // Device 3 holds its grant without starting a transfer, so the grant times out.
        bus.req_n = 4'hF;
        step();
        bus.req_n = 4'b0111;
        step();
        cnt = 0;
        while (bus.gnt_n === 4'b0111 && cnt < 40) begin
            cnt++;
            step();
        end
        check("timeout_len", 32'(cnt), 32'd16);
        check("timeout_rel", 32'(bus.gnt_n), 32'hF);
        bus.req_n = 4'b0110;
        step();
        check("after_to", 32'(bus.gnt_n), 32'b1110);

        // Device 2 drops its request before FRAME#. last_owner keeps its value.
        bus.req_n = 4'hF;
        step();
        bus.req_n = 4'b1011;
        step();
        check("grant_dev2", 32'(bus.gnt_n), 32'b1011);
        bus.req_n = 4'hF;
        step();
        check("dev2_release", 32'(bus.gnt_n), 32'hF);
        bus.req_n = 4'b0000;
        step();
        check("last_kept", 32'(bus.gnt_n), 32'b1110);
        bus.req_n = 4'hF;
        step();

        // Another master owns the bus, so no grant is given until FRAME# and IRDY# are both high.
        bus.req_n   = 4'b1101;
        bus.frame_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_frame", 32'(bus.gnt_n), 32'hF);
        end
        bus.frame_n = 1'b1;
        bus.irdy_n  = 1'b0;
        step();
        check("hold_irdy", 32'(bus.gnt_n), 32'hF);
        bus.irdy_n = 1'b1;
        step();
        check("grant_idle", 32'(bus.gnt_n), 32'b1101);

        // Reset in the middle of a transfer.
        bus.frame_n = 1'b0;
        step();
        check("busy_pre_rst", 32'(bus.bus_busy), 32'd1);
        reset = 1'b1;
        step();
        check("rst_gnt", 32'(bus.gnt_n), 32'hF);
        check("rst_busy", 32'(bus.bus_busy), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        reset       = 1'b0;
        bus.frame_n = 1'b1;
        bus.req_n   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_order", 32'(bus.owner), 32'(exp_order[i]));
            bus.frame_n = 1'b0;
            step();
            bus.frame_n = 1'b1;
            step();
        end

        // Random traffic compared cycle by cycle against the model.
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) < 2);
            bus.req_n   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.req_n = 4'hF;
            bus.frame_n = ($urandom_range(0, 9) >= 3);
            bus.irdy_n  = ($urandom_range(0, 9) >= 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
